// File: rtl/router_ingress_replay.sv
// Per-port ingress stage: store-and-forward one frame, drive it to the
// output muxes, and replay it after a linear backoff when a collision is seen.
module router_ingress_replay #(
  parameter int AW          = 6,
  parameter int DestLsb     = 0,
  parameter int CheckCycles = 8,
  parameter int BackoffBase = 16,
  parameter int MaxRetry    = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] RX_D,
  input  logic        RX_HDR_VALID,
  input  logic        RX_PLD_VALID,
  input  logic        RX_SOF,
  input  logic        RX_EOF,
  output logic        RX_BP,
  output logic [63:0] D,
  output logic [7:0]  DEST,
  output logic        DEST_VALID,
  output logic        D_HDR_VALID,
  output logic        D_PLD_VALID,
  output logic        D_SOF,
  output logic        D_EOF,
  input  logic        D_BP,
  input  logic        COLLISION,
  output logic        DROP,
  output logic [1:0]  RETRY_CNT
);

  localparam int Depth = 2 ** AW;
  localparam int CW    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SEND,
    S_CHECK,
    S_BACKOFF
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [64:0]   r_mem [Depth];
  logic [AW:0]   r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_last;
  logic [CW-1:0] r_cnt;
  logic          r_flag;
  logic [1:0]    r_retry;
  logic [7:0]    r_dest;
  logic [63:0]   r_d;
  logic          r_hdr_v;
  logic          r_pld_v;
  logic          r_sof;
  logic          r_eof;
  logic          r_drop;

  logic          w_acc;
  logic          w_col;
  logic          w_cnt_end;
  logic          w_retry_max;
  logic [CW-1:0] w_bo_len;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic          w_start;
  logic          w_ovf;
  logic          w_issue;
  logic          w_to_check;
  logic          w_to_backoff;
  logic          w_exhaust;
  logic          w_replay;
  logic          w_chk_done;

  assign RX_BP       = (r_state == S_SEND) || (r_state == S_CHECK) ||
                       (r_state == S_BACKOFF);
  assign DEST_VALID  = (r_state == S_SEND) || (r_state == S_CHECK);
  assign DEST        = r_dest;
  assign D           = r_d;
  assign D_HDR_VALID = r_hdr_v;
  assign D_PLD_VALID = r_pld_v;
  assign D_SOF       = r_sof;
  assign D_EOF       = r_eof;
  assign DROP        = r_drop;
  assign RETRY_CNT   = r_retry;

  assign w_acc       = (RX_HDR_VALID | RX_PLD_VALID) & ~RX_BP;
  assign w_col       = r_flag | COLLISION;
  assign w_cnt_end   = (r_cnt == CW'(1));
  assign w_retry_max = (r_retry == 2'(MaxRetry));
  assign w_bo_len    = CW'(BackoffBase) * (CW'(r_retry) + CW'(1));
  assign w_chk_done  = (r_state == S_CHECK) && w_cnt_end;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_wr_en      = 1'b0;
    w_wr_addr    = '0;
    w_start      = 1'b0;
    w_ovf        = 1'b0;
    w_issue      = 1'b0;
    w_to_check   = 1'b0;
    w_to_backoff = 1'b0;
    w_exhaust    = 1'b0;
    w_replay     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && RX_SOF) begin
          w_wr_en = 1'b1;
          w_start = 1'b1;
          w_next  = RX_EOF ? S_SEND : S_FILL;
        end
      end
      S_FILL: begin
        if (w_acc) begin
          if (RX_SOF) begin
            w_wr_en = 1'b1;
            w_start = 1'b1;
            if (RX_EOF) w_next = S_SEND;
          end else if (r_wr_ptr == (AW+1)'(Depth)) begin
            w_ovf  = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_wr_ptr[AW-1:0];
            if (RX_EOF) w_next = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (!D_BP) begin
          w_issue = 1'b1;
          if (r_rd_ptr == r_last) begin
            w_to_check = 1'b1;
            w_next     = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (w_cnt_end) begin
          if (!w_col) begin
            w_next = S_IDLE;
          end else if (w_retry_max) begin
            w_exhaust = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_to_backoff = 1'b1;
            w_next       = S_BACKOFF;
          end
        end
      end
      S_BACKOFF: begin
        if (w_cnt_end) begin
          w_replay = 1'b1;
          w_next   = S_SEND;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[w_wr_addr] <= {RX_HDR_VALID, RX_D};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
      r_cnt    <= '0;
      r_flag   <= 1'b0;
      r_retry  <= '0;
      r_dest   <= '0;
      r_d      <= '0;
      r_hdr_v  <= 1'b0;
      r_pld_v  <= 1'b0;
      r_sof    <= 1'b0;
      r_eof    <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_hdr_v <= 1'b0;
      r_pld_v <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_drop  <= w_ovf | w_exhaust;
      if (w_start) r_dest <= RX_D[DestLsb +: 8];
      if (w_wr_en) begin
        r_wr_ptr <= w_start ? (AW+1)'(1) : r_wr_ptr + 1'b1;
        r_rd_ptr <= '0;
        if (RX_EOF) r_last <= w_wr_addr;
      end
      if (w_issue) begin
        r_d      <= r_mem[r_rd_ptr][63:0];
        r_hdr_v  <= r_mem[r_rd_ptr][64];
        r_pld_v  <= ~r_mem[r_rd_ptr][64];
        r_sof    <= (r_rd_ptr == '0);
        r_eof    <= (r_rd_ptr == r_last);
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_to_check)        r_cnt <= CW'(CheckCycles);
      else if (w_to_backoff) r_cnt <= w_bo_len;
      else if (r_state == S_CHECK || r_state == S_BACKOFF)
        r_cnt <= r_cnt - 1'b1;
      // sticky until the attempt is judged; cleared for each replay
      if (w_replay || r_state == S_IDLE)
        r_flag <= 1'b0;
      else if ((r_state == S_SEND || r_state == S_CHECK) && COLLISION)
        r_flag <= 1'b1;
      if (w_replay) begin
        r_retry  <= r_retry + 1'b1;
        r_rd_ptr <= '0;
      end else if (w_chk_done && (w_next == S_IDLE)) begin
        r_retry <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_ingress_replay.sv
// Scoreboard bench for router_ingress_replay: random frames, collisions
// and mux backpressure checked against a frame-level replay model.
module tb_router_ingress_replay;

  localparam int CheckCycles = 8;
  localparam int BackoffBase = 16;
  localparam int MaxRetry    = 3;
  localparam int MaxLen      = 64;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] RX_D;
  logic        RX_HDR_VALID;
  logic        RX_PLD_VALID;
  logic        RX_SOF;
  logic        RX_EOF;
  logic        RX_BP;
  logic [63:0] D;
  logic [7:0]  DEST;
  logic        DEST_VALID;
  logic        D_HDR_VALID;
  logic        D_PLD_VALID;
  logic        D_SOF;
  logic        D_EOF;
  logic        D_BP;
  logic        COLLISION;
  logic        DROP;
  logic [1:0]  RETRY_CNT;

  router_ingress_replay dut (
    .CLK(CLK), .RST(RST),
    .RX_D(RX_D), .RX_HDR_VALID(RX_HDR_VALID), .RX_PLD_VALID(RX_PLD_VALID),
    .RX_SOF(RX_SOF), .RX_EOF(RX_EOF), .RX_BP(RX_BP),
    .D(D), .DEST(DEST), .DEST_VALID(DEST_VALID),
    .D_HDR_VALID(D_HDR_VALID), .D_PLD_VALID(D_PLD_VALID),
    .D_SOF(D_SOF), .D_EOF(D_EOF), .D_BP(D_BP),
    .COLLISION(COLLISION), .DROP(DROP), .RETRY_CNT(RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] d;
    logic        hdr;
    logic        sof;
    logic        eof;
    logic [7:0]  dest;
    logic [1:0]  retry;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   obs_drops = 0;
  int   exp_drops = 0;
  int   coll_left = 0;
  int   coll_dly = -1;
  bit   gap_chk = 1'b1;
  bit   rand_bp = 1'b0;
  bit   bp_hold = 1'b0;
  bit   bubble_en = 1'b0;
  int   last_sof_cyc = 0;
  int   last_eof_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // monitor: pops one expected word per valid output word
  initial begin
    exp_t e;
    int   gap;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (DROP) obs_drops++;
        if (D_HDR_VALID || D_PLD_VALID) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got D=%h sof=%b eof=%b want none",
                     D, D_SOF, D_EOF);
          end else begin
            e = q.pop_front();
            if ({D, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF, DEST, DEST_VALID,
                 RETRY_CNT} !== {e.d, e.hdr, ~e.hdr, e.sof, e.eof, e.dest,
                 1'b1, e.retry}) begin
              errors++;
              $display("FAIL word got D=%h h=%b p=%b s=%b e=%b dst=%0d dv=%b rc=%0d want D=%h h=%b s=%b e=%b dst=%0d rc=%0d",
                       D, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF, DEST,
                       DEST_VALID, RETRY_CNT, e.d, e.hdr, e.sof, e.eof,
                       e.dest, e.retry);
            end
            if (D_SOF) begin
              if (gap_chk && e.retry != 0) begin
                gap = CheckCycles + BackoffBase * int'(e.retry) + 1;
                checks++;
                if (cyc - last_eof_cyc != gap) begin
                  errors++;
                  $display("FAIL backoff_gap got %0d want %0d",
                           cyc - last_eof_cyc, gap);
                end
              end
              last_sof_cyc = cyc;
            end
            if (D_EOF) last_eof_cyc = cyc;
          end
        end else begin
          checks++;
          if (D_SOF || D_EOF) begin
            errors++;
            $display("FAIL bubble_flags got sof=%b eof=%b want 0 0",
                     D_SOF, D_EOF);
          end
        end
      end
    end
  end

  // collision injector: pulses COLLISION inside the check window
  initial begin
    int dly;
    COLLISION = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST && D_EOF && (D_HDR_VALID || D_PLD_VALID) && coll_left > 0) begin
        coll_left--;
        dly = (coll_dly >= 0) ? coll_dly : int'($urandom_range(0, 6));
        repeat (dly) @(negedge CLK);
        COLLISION = 1'b1;
        @(negedge CLK);
        COLLISION = 1'b0;
      end
    end
  end

  // mux backpressure driver
  initial begin
    D_BP = 1'b0;
    forever begin
      @(negedge CLK);
      if (bubble_en && D_SOF && !RST) begin
        D_BP = 1'b1;
        repeat (3) @(negedge CLK);
        D_BP = 1'b0;
      end else begin
        D_BP = bp_hold || (rand_bp && $urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic drive_words(input logic [63:0] w[$], input bit gaps,
                             output int eof_c);
    int len;
    len = w.size();
    eof_c = 0;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 4) == 0) begin
          RX_HDR_VALID = 1'b0;
          RX_PLD_VALID = 1'b0;
          RX_SOF = 1'b0;
          RX_EOF = 1'b0;
          @(negedge CLK);
        end
      end
      RX_D = w[i];
      RX_HDR_VALID = (i == 0);
      RX_PLD_VALID = (i != 0);
      RX_SOF = (i == 0);
      RX_EOF = (i == len - 1);
      eof_c = cyc;
      @(negedge CLK);
    end
    RX_HDR_VALID = 1'b0;
    RX_PLD_VALID = 1'b0;
    RX_SOF = 1'b0;
    RX_EOF = 1'b0;
  endtask

  task automatic run_frame(input int len, input logic [7:0] dest,
                           input int ncoll, input bit gaps, input bit stray,
                           output int eof_c, output int idle_c);
    logic [63:0] w[$];
    logic [63:0] x;
    exp_t        e;
    int          att;
    int          n;
    for (int i = 0; i < len; i++) begin
      x = {$urandom, $urandom};
      if (i == 0) x[7:0] = dest;
      w.push_back(x);
    end
    // frame-level model: an overlong frame vanishes; otherwise it is sent
    // once per attempt until a clean attempt or the retry budget runs out
    if (len > MaxLen) begin
      exp_drops++;
      coll_left = 0;
    end else begin
      att = (ncoll > MaxRetry) ? MaxRetry + 1 : ncoll + 1;
      for (int a = 0; a < att; a++)
        for (int i = 0; i < len; i++) begin
          e.d = w[i];
          e.hdr = (i == 0);
          e.sof = (i == 0);
          e.eof = (i == len - 1);
          e.dest = dest;
          e.retry = 2'(a);
          q.push_back(e);
        end
      if (ncoll > MaxRetry) exp_drops++;
      coll_left = ncoll;
    end
    if (stray) begin
      RX_D = {$urandom, $urandom};
      RX_PLD_VALID = 1'b1;
      RX_EOF = $urandom_range(0, 1) == 1;
      @(negedge CLK);
      RX_PLD_VALID = 1'b0;
      RX_EOF = 1'b0;
    end
    drive_words(w, gaps, eof_c);
    n = 0;
    while (RX_BP && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    idle_c = cyc;
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got RX_BP=%b want 0", RX_BP);
    end
    repeat (2) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL words_left got %0d want 0", q.size());
      q.delete();
    end
    checks++;
    if (obs_drops != exp_drops) begin
      errors++;
      $display("FAIL drop_count got %0d want %0d", obs_drops, exp_drops);
    end
    checks++;
    if (RETRY_CNT !== 2'd0 || DEST_VALID !== 1'b0) begin
      errors++;
      $display("FAIL idle_state got rc=%0d dv=%b want 0 0",
               RETRY_CNT, DEST_VALID);
    end
    coll_left = 0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ({D, DEST, DEST_VALID, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF,
         DROP, RETRY_CNT, RX_BP} !== '0) begin
      errors++;
      $display("FAIL %s got D=%h dst=%0d dv=%b h=%b p=%b s=%b e=%b drop=%b rc=%0d bp=%b want all 0",
               name, D, DEST, DEST_VALID, D_HDR_VALID, D_PLD_VALID, D_SOF,
               D_EOF, DROP, RETRY_CNT, RX_BP);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eof_c;
    int idle_c;
    logic [63:0] w[$];
    RST = 1'b1;
    RX_D = '0;
    RX_HDR_VALID = 1'b0;
    RX_PLD_VALID = 1'b0;
    RX_SOF = 1'b0;
    RX_EOF = 1'b0;
    repeat (3) @(negedge CLK);
    chk_zero("reset_state");
    RST = 1'b0;
    @(negedge CLK);

    run_frame(4, 8'd2, 0, 1'b0, 1'b0, eof_c, idle_c);
    chk("first_word_latency", last_sof_cyc, eof_c + 2);
    chk("back_to_back", last_eof_cyc, last_sof_cyc + 3);
    chk("check_window", idle_c, last_eof_cyc + CheckCycles);

    bubble_en = 1'b1;
    run_frame(4, 8'd2, 0, 1'b0, 1'b0, eof_c, idle_c);
    bubble_en = 1'b0;
    chk("bubble_span", last_eof_cyc - last_sof_cyc, 3 + 3);

    coll_dly = 2;
    run_frame(4, 8'd2, 1, 1'b0, 1'b0, eof_c, idle_c);
    chk("replay_ok_window", idle_c, last_eof_cyc + CheckCycles);
    coll_dly = -1;

    run_frame(4, 8'd5, 4, 1'b0, 1'b0, eof_c, idle_c);

    run_frame(65, 8'd7, 0, 1'b0, 1'b0, eof_c, idle_c);
    run_frame(4, 8'd9, 0, 1'b0, 1'b0, eof_c, idle_c);
    run_frame(64, 8'd200, 0, 1'b0, 1'b0, eof_c, idle_c);

    bp_hold = 1'b1;
    for (int i = 0; i < 6; i++) w.push_back({$urandom, $urandom});
    drive_words(w, 1'b0, eof_c);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_zero("reset_mid_send");
    RST = 1'b0;
    bp_hold = 1'b0;
    @(negedge CLK);
    run_frame(1, 8'd3, 0, 1'b0, 1'b0, eof_c, idle_c);
    chk("one_word_sof_eof", last_eof_cyc, last_sof_cyc);

    gap_chk = 1'b0;
    rand_bp = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int r;
      int nc;
      r = int'($urandom_range(0, 9));
      nc = (r < 6) ? 0 : r - 5;
      run_frame(int'($urandom_range(1, 12)), 8'($urandom), nc, 1'b1,
                $urandom_range(0, 2) == 0, eof_c, idle_c);
    end
    rand_bp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
